// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job sequencer: state encoding and default sizing constants.
package gcd_pkg;

    localparam int unsigned GCD_W           = 8;
    localparam int unsigned GCD_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD_A,
        LOAD_B,
        RUN,
        BYP,
        RESP
    } gcd_state_t;

endpackage

// File: rtl/gcd_job_sequencer.sv
// Job front end for the GCD core: clears the core, loads A then B, waits for done, returns the result.
// Optional RUN watchdog enabled by defining GCD_TIMEOUT_EN.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int unsigned W           = GCD_W,
    parameter int unsigned TIMEOUT_CYC = GCD_TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         core_rst_n,
    output logic         core_start,
    output logic [W-1:0] core_data_in,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         out_err
);

    gcd_state_t   state, state_next;
    logic [W-1:0] a_q, b_q;
    logic [W-1:0] gcd_next;
    logic         err_next;
    logic         timeout_hit;

`ifdef GCD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (state == LOAD_A) begin
            run_cnt <= '0;
        end else if (state == RUN) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // Fires on the RUN cycle whose increment would reach TIMEOUT_CYC.
    assign timeout_hit = (run_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        gcd_next   = out_gcd;
        err_next   = out_err;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = ((in_a == '0) || (in_b == '0)) ? BYP : CLR;
                end
            end
            CLR:    state_next = LOAD_A;
            LOAD_A: state_next = LOAD_B;
            LOAD_B: state_next = RUN;
            RUN: begin
                if (core_done) begin
                    state_next = RESP;
                    gcd_next   = core_result;
                    err_next   = 1'b0;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    gcd_next   = '0;
                    err_next   = 1'b1;
                end
            end
            BYP: begin
                state_next = RESP;
                gcd_next   = a_q | b_q;
                err_next   = (a_q == '0) && (b_q == '0);
            end
            RESP: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if ((state == IDLE) && in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready     <= 1'b1;
            core_rst_n   <= 1'b0;
            core_start   <= 1'b0;
            core_data_in <= '0;
            out_valid    <= 1'b0;
            out_gcd      <= '0;
            out_err      <= 1'b0;
        end else begin
            in_ready     <= (state_next == IDLE);
            core_rst_n   <= (state_next == LOAD_A) || (state_next == LOAD_B) || (state_next == RUN);
            core_start   <= (state_next == LOAD_A);
            core_data_in <= (state_next == LOAD_A) ? a_q :
                            (state_next == LOAD_B) ? b_q : '0;
            out_valid    <= (state_next == RESP);
            out_gcd      <= gcd_next;
            out_err      <= err_next;
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Randomized self-checking bench for gcd_job_sequencer with a behavioural GCD core model.
module tb_gcd_job_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic       core_rst_n;
    logic       core_start;
    logic [7:0] core_data_in;
    logic       core_done;
    logic [7:0] core_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_gcd;
    logic       out_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcd_job_sequencer #(.W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_rst_n(core_rst_n), .core_start(core_start), .core_data_in(core_data_in),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference result: Euclid on nonzero operands, otherwise the nonzero operand (0 if both zero).
    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int unsigned x, y, t;
        if (a == 0 || b == 0) return a | b;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[7:0];
    endfunction

    // Core model: takes A on the start edge, B on the following edge, answers after job_delay cycles.
    int         phase;
    int         dly;
    int         job_delay = 0;
    bit         core_hang = 0;
    logic [7:0] cap_a, cap_b;

    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            phase       <= 0;
            core_done   <= 1'b0;
            core_result <= 8'h00;
        end else begin
            case (phase)
                0: if (core_start) begin cap_a <= core_data_in; phase <= 1; end
                1: begin cap_b <= core_data_in; dly <= job_delay; phase <= 2; end
                2: if (!core_hang) begin
                       if (dly == 0) begin
                           core_done   <= 1'b1;
                           core_result <= ref_gcd(cap_a, cap_b);
                           phase       <= 3;
                       end else begin
                           dly <= dly - 1;
                       end
                   end
                default: ;
            endcase
        end
    end

    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [7:0] eg;
        logic       ee;
        int         el, lat, starts, n;
        bit         core_path;
        logic       clr_low;
        core_path = (a != 0) && (b != 0);
        if (core_hang && core_path) begin
            eg = 8'h00; ee = 1'b1; el = 20;
        end else begin
            eg = ref_gcd(a, b);
            ee = (a == 0) && (b == 0);
            el = core_path ? 6 + job_delay : 2;
        end
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        check("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; starts = 0;
        clr_low = ~core_rst_n;
        while (!out_valid && lat < 400) begin
            starts += int'(core_start);
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", out_valid, 1'b1);
        check("latency", lat, el);
        check("gcd", out_gcd, eg);
        check("err", out_err, ee);
        check("start_pulses", starts, core_path ? 1 : 0);
        if (core_path) begin
            check("core_clear", clr_low, 1'b1);
            check("bus_a", cap_a, a);
            check("bus_b", cap_b, b);
        end
        repeat (hold) begin
            @(negedge clk);
            check("backpressure_hold", {out_valid, in_ready, out_err, out_gcd}, {1'b1, 1'b0, ee, eg});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("consume", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench stalled");
    end

    initial begin
        logic [7:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {in_ready, core_rst_n, core_start, core_data_in, out_valid, out_gcd, out_err},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        rst_n = 1'b1;

        job_delay = 3;  run_job(8'd36, 8'd24, 0);
        run_job(8'd0, 8'd9, 0);
        run_job(8'd0, 8'd0, 0);
        run_job(8'd9, 8'd0, 1);
        job_delay = 0;  run_job(8'd17, 8'd17, 10);
        job_delay = 5;  run_job(8'd48, 8'd18, 0);
        job_delay = 2;  run_job(8'd7, 8'd5, 0);
        run_job(8'd255, 8'd1, 0);

        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? ra : (($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
            job_delay = $urandom_range(0, 12);
            run_job(ra, rb, $urandom_range(0, 3));
        end

`ifdef GCD_TIMEOUT_EN
        core_hang = 1;
        run_job(8'd100, 8'd75, 2);
        core_hang = 0;
        job_delay = 1;
        run_job(8'd100, 8'd75, 0);
`endif

        // Reset while the core is still computing.
        job_delay = 60;
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'd36; in_b = 8'd24;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_run", {in_ready, core_rst_n, core_start, core_data_in, out_valid, out_gcd, out_err},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        job_delay = 4;
        run_job(8'd36, 8'd24, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
